// File: rtl/aud_divider_pair.sv
// aud_divider_pair: one POKEY channel pair divider (8-bit, 16-bit joined, fast clock).
// Optional sticky IRQ flags per channel when AUD_TIMER_IRQ_EN is defined.
// reset_n is asserted asynchronously; its release is expected to be synchronised upstream.
module aud_divider_pair #(
    parameter int CNT_W      = 8,
    parameter int FAST_OFS8  = 3,
    parameter int FAST_OFS16 = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enn,
    input  logic             audClock,
    input  logic             fastA,
    input  logic             join16,
    input  logic             stimer,
    input  logic [CNT_W-1:0] audfA,
    input  logic [CNT_W-1:0] audfB,
`ifdef AUD_TIMER_IRQ_EN
    input  logic             irqClrA,
    input  logic             irqClrB,
    output logic             irqA,
    output logic             irqB,
`endif
    output logic             pulseA,
    output logic             pulseB
);
    localparam logic [CNT_W-1:0]   OFS8  = CNT_W'(FAST_OFS8);
    localparam logic [2*CNT_W-1:0] OFS16 = (2*CNT_W)'(FAST_OFS16);

    logic [CNT_W-1:0]   cntA_q, cntA_d, cntB_q, cntB_d, rldA;
    logic [2*CNT_W-1:0] cnt16, rld16;
    logic               pulseA_q, pulseA_d, pulseB_q, pulseB_d, tickA;

    assign tickA = fastA | audClock;
    assign cnt16 = {cntB_q, cntA_q};
    assign rldA  = audfA + (fastA ? OFS8 : '0);
    assign rld16 = {audfB, audfA} + (fastA ? OFS16 : '0);

    // Next-state: stimer reload beats ticks; joined mode borrows A into B in the same cycle
    always_comb begin
        cntA_d   = cntA_q;
        cntB_d   = cntB_q;
        pulseA_d = 1'b0;
        pulseB_d = 1'b0;
        if (stimer) begin
            if (join16) {cntB_d, cntA_d} = rld16;
            else begin
                cntA_d = rldA;
                cntB_d = audfB;
            end
        end else if (join16) begin
            if (tickA) begin
                if (cnt16 == '0) begin
                    {cntB_d, cntA_d} = rld16;
                    pulseB_d         = 1'b1;
                end else {cntB_d, cntA_d} = cnt16 - (2*CNT_W)'(1);
            end
        end else begin
            if (tickA) begin
                if (cntA_q == '0) begin
                    cntA_d   = rldA;
                    pulseA_d = 1'b1;
                end else cntA_d = cntA_q - CNT_W'(1);
            end
            if (audClock) begin
                if (cntB_q == '0) begin
                    cntB_d   = audfB;
                    pulseB_d = 1'b1;
                end else cntB_d = cntB_q - CNT_W'(1);
            end
        end
    end

`ifdef AUD_TIMER_IRQ_EN
    logic irqA_q, irqB_q;

    // Sticky flags: a set in the same cycle as a clear wins
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqA_q <= 1'b0;
            irqB_q <= 1'b0;
        end else if (enn) begin
            irqA_q <= pulseA_d | (irqA_q & ~irqClrA);
            irqB_q <= pulseB_d | (irqB_q & ~irqClrB);
        end
    end

    assign irqA = irqA_q;
    assign irqB = irqB_q;
`endif

    // Counter and pulse registers advance only on phase-2 enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cntA_q   <= '0;
            cntB_q   <= '0;
            pulseA_q <= 1'b0;
            pulseB_q <= 1'b0;
        end else if (enn) begin
            cntA_q   <= cntA_d;
            cntB_q   <= cntB_d;
            pulseA_q <= pulseA_d;
            pulseB_q <= pulseB_d;
        end
    end

    assign pulseA = pulseA_q;
    assign pulseB = pulseB_q;
endmodule

// File: tb/tb_aud_divider_pair.sv
// tb_aud_divider_pair: directed bench for aud_divider_pair (IRQ steps when AUD_TIMER_IRQ_EN is defined).
module tb_aud_divider_pair;
    logic       clk = 1'b0, reset_n = 1'b0, enn = 1'b1, audClock = 1'b0;
    logic       fastA = 1'b0, join16 = 1'b0, stimer = 1'b0;
    logic [7:0] audfA = 8'd0, audfB = 8'd0;
    logic       pulseA, pulseB;
`ifdef AUD_TIMER_IRQ_EN
    logic       irqClrA = 1'b0, irqClrB = 1'b0, irqA, irqB;
`endif
    int n_chk = 0, n_pass = 0, n_fail = 0;
    int na, nb, ga, gb;

    aud_divider_pair dut (
        .clk(clk), .reset_n(reset_n), .enn(enn), .audClock(audClock),
        .fastA(fastA), .join16(join16), .stimer(stimer),
        .audfA(audfA), .audfB(audfB),
`ifdef AUD_TIMER_IRQ_EN
        .irqClrA(irqClrA), .irqClrB(irqClrB), .irqA(irqA), .irqB(irqB),
`endif
        .pulseA(pulseA), .pulseB(pulseB)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs ncyc enabled cycles with audClock every per cycles (per = 0: never);
    // counts pulses and the last gap between consecutive pulses per channel.
    task automatic run(input int ncyc, input int per, output int pa, output int pb,
                       output int gpa, output int gpb);
        int la, lb;
        pa = 0; pb = 0; gpa = 0; gpb = 0; la = -1; lb = -1;
        for (int i = 0; i < ncyc; i++) begin
            audClock = (per > 0) && (i % per == 0);
            cyc();
            if (pulseA) begin
                if (la >= 0) gpa = i - la;
                la = i;
                pa++;
            end
            if (pulseB) begin
                if (lb >= 0) gpb = i - lb;
                lb = i;
                pb++;
            end
        end
        audClock = 1'b0;
    endtask

    initial begin
        cyc();
        chk("rst_pulseA", pulseA, 0);
        chk("rst_pulseB", pulseB, 0);
        chk("rst_cntA", dut.cntA_q, 0);
        reset_n = 1'b1; audfA = 8'd4; audfB = 8'd2; audClock = 1'b1;
        cyc();
        chk("first_pulseA", pulseA, 1);
        chk("first_pulseB", pulseB, 1);
        audClock = 1'b0;

        run(420, 28, na, nb, ga, gb);
        chk("base_countA", na, 3);
        chk("base_gapA", ga, 140);
        chk("base_countB", nb, 5);
        chk("base_gapB", gb, 84);

        fastA = 1'b1; audfA = 8'd10; stimer = 1'b1;
        cyc();
        stimer = 1'b0;
        chk("fast_stimer_cntA", dut.cntA_q, 13);
        run(56, 0, na, nb, ga, gb);
        chk("fast_countA", na, 4);
        chk("fast_gapA", ga, 14);
        chk("fast_countB", nb, 0);
        enn = 1'b0;
        repeat (5) cyc();
        chk("enn_freeze_cntA", dut.cntA_q, 13);
        enn = 1'b1;

        join16 = 1'b1; audfB = 8'd1; audfA = 8'd0; stimer = 1'b1;
        cyc();
        stimer = 1'b0;
        chk("join_ld_cntA", dut.cntA_q, 6);
        chk("join_ld_cntB", dut.cntB_q, 1);
        chk("join_ld_pulseB", pulseB, 0);
        run(526, 0, na, nb, ga, gb);
        chk("join_countB", nb, 2);
        chk("join_gapB", gb, 263);
        chk("join_countA", na, 0);

        join16 = 1'b0; fastA = 1'b0; audfA = 8'd4; stimer = 1'b1;
        cyc();
        stimer = 1'b0;
        run(2, 1, na, nb, ga, gb);
        chk("reload_early", na, 0);
        audfA = 8'd9;
        run(3, 1, na, nb, ga, gb);
        chk("reload_old_period", na, 1);
        run(20, 1, na, nb, ga, gb);
        chk("reload_new_count", na, 2);
        chk("reload_new_gap", ga, 10);
        run(9, 1, na, nb, ga, gb);
        chk("pre_stimer_cntA", dut.cntA_q, 0);
        audClock = 1'b1; stimer = 1'b1;
        cyc();
        stimer = 1'b0;
        chk("stimer_tick_pulseA", pulseA, 0);
        chk("stimer_tick_cntA", dut.cntA_q, 9);

        cyc();
        cyc();
        chk("mid_pulseB", pulseB, 1);
        audClock = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("async_pulseB", pulseB, 0);
        chk("async_cntA", dut.cntA_q, 0);
        chk("async_cntB", dut.cntB_q, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        audClock = 1'b1;
        cyc();
        audClock = 1'b0;
        chk("release_pulseA", pulseA, 1);
        chk("release_pulseB", pulseB, 1);

        audfA = 8'd0; stimer = 1'b1;
        cyc();
        stimer = 1'b0;
        run(5, 1, na, nb, ga, gb);
        chk("audf0_countA", na, 5);

`ifdef AUD_TIMER_IRQ_EN
        chk("irq_set", irqA, 1);
        irqClrA = 1'b1;
        cyc();
        chk("irq_clear", irqA, 0);
        audClock = 1'b1;
        cyc();
        chk("irq_set_and_clear", irqA, 1);
        audClock = 1'b0; irqClrA = 1'b0;
        cyc();
        chk("irq_sticky", irqA, 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
